fifo_ff_prog: RTL
=================

// Module: fifo_ff_prog
// PURPOSE
//  Next-generation flip-flop FIFO for the event data path: buffers packet words between
//  the event builder and the TX/serializer logic. Generalises the existing FIFO with:
//  - programmable almost-full/almost-empty thresholds
//  - selectable standard or first-word-fall-through (FWFT) read mode
//  - saturating overflow/underflow counters
//  - high-water-mark register for on-chip occupancy diagnostics
// PARAMETERS
//  FIFO_WIDTH  64   width of each FIFO word (bits)
//  FIFO_DEPTH  256  number of words; power of two, >= 4
//  FIFO_BITS   8    log2(FIFO_DEPTH); pointer width
//  FWFT        0    0 = standard read (1-cycle latency); 1 = first-word-fall-through
//  STAT_BITS   16   width of overflow/underflow counters
// PORTS
//  clk                  in   1             master clock; all logic on rising edge
//  reset_n              in   1             asynchronous digital reset, active low
//  data_in              in   FIFO_WIDTH    write data
//  write_n              in   1             write strobe, active low
//  read_n               in   1             read/pop strobe, active low
//  almost_full_thresh   in   FIFO_BITS+1   almost_full asserts when count >= value
//  almost_empty_thresh  in   FIFO_BITS+1   almost_empty asserts when count <= value
//  clear_stats          in   1             sync pulse: clear overflow/underflow counts, high_water
//  data_out             out  FIFO_WIDTH    read data
//  data_valid           out  1             data_out holds a valid popped/head word
//  fifo_counter         out  FIFO_BITS+1   words currently stored (0..FIFO_DEPTH)
//  fifo_full            out  1             count == FIFO_DEPTH
//  fifo_half            out  1             count >= FIFO_DEPTH/2
//  fifo_empty           out  1             count == 0
//  fifo_almost_full     out  1             count >= almost_full_thresh
//  fifo_almost_empty    out  1             count <= almost_empty_thresh
//  overflow_cnt         out  STAT_BITS     dropped writes, saturating
//  underflow_cnt        out  STAT_BITS     rejected reads, saturating
//  high_water           out  FIFO_BITS+1   max count since reset/clear_stats
// BEHAVIOUR
//  - One clock, clk. reset_n is asynchronous, active low, and fixed as such.
//  - Reset:
//    - Outputs go to 0, except fifo_empty = 1 and fifo_almost_empty = 1.
//    - Pointers and count go to 0. Storage is not cleared.
//    - Reset mid-operation discards contents and in-flight reads.
//  - Write: accepted when write_n = 0 and (!fifo_full, or a pop occurs in the same cycle).
//    Accepted data is stored at wr_ptr and wr_ptr increments modulo FIFO_DEPTH.
//  - Pop: accepted when read_n = 0 and !fifo_empty. The count before the edge is used, so a
//    same-cycle write to an empty FIFO does not satisfy the read. rd_ptr increments modulo
//    FIFO_DEPTH.
//  - Pointer wrap is natural binary roll-over at FIFO_BITS. Occupancy comes from a separate
//    count register, never from pointer difference.
//  - Simultaneous accepted write and pop: count unchanged. This also holds when full.
//  - Write while full with no pop: the word is dropped, contents are unchanged, and
//    overflow_cnt increments.
//  - Read while empty: ignored, underflow_cnt increments, data_out holds its last value.
//  - Standard mode (FWFT = 0):
//    - data_out registered; the popped word appears on the edge after the pop.
//    - data_valid = 1 for exactly that one cycle.
//  - FWFT mode (FWFT = 1):
//    - data_out = head word whenever !fifo_empty; data_valid = !fifo_empty.
//    - read_n = 0 acknowledges the word; the next head is presented on the following edge.
//    - A word written into an empty FIFO appears on data_out one cycle after the write edge.
//  - Flags are registered and derived from the updated count in the same edge.
//    They are valid the cycle after the causing event.
//  - Threshold edge cases:
//    - almost_full_thresh = 0: fifo_almost_full is always 1.
//    - almost_full_thresh > FIFO_DEPTH: fifo_almost_full is never set.
//    - Thresholds may change at any time and take effect on the next edge.
//  - Stat counters saturate at all-ones.
//  - high_water updates when the updated count exceeds it.
//  - clear_stats: zeroes overflow_cnt and underflow_cnt and loads high_water with the
//    updated count. It has priority over a same-cycle overflow/underflow, which is not counted.
// TESTING
//  1. Reset, both modes:
//     - Hold reset_n = 0 for 3 clk -> fifo_empty = 1, almost_empty = 1, counter = 0, stats = 0.
//     - Assert reset_n low mid-stream with 10 words stored -> counter = 0 asynchronously.
//  2. Fill to full with DEPTH = 256:
//     - Write 0..255 -> fifo_full = 1, counter = 256, high_water = 256.
//     - Write 3 more -> overflow_cnt = 3.
//     - Drain -> data 0..255 in order, across pointer wrap.
//  3. Full with simultaneous write (0xAA) and read:
//     - Counter stays 256 and overflow_cnt stays 0.
//     - 0xAA is read last after the drain.
//  4. Empty-FIFO read:
//     - 5 reads -> underflow_cnt = 5, data_out unchanged.
//     - Read and write of 0x55 in the same cycle -> write accepted, underflow_cnt = 6.
//  5. Thresholds af = 200, ae = 10:
//     - Count 199 -> 200: almost_full rises on that edge.
//     - Count 11 -> 10: almost_empty rises.
//     - Change af to 100 with count 150 -> almost_full = 1 on the next edge.
//  6. Modes and stats:
//     - FWFT = 1: write 0x1234 into empty -> data_out = 0x1234, data_valid = 1 the next cycle.
//     - Pulse clear_stats with count 40 -> stats = 0, high_water = 40.

Source files
------------

// File: rtl/fifo_ff_prog.sv
// fifo_ff_prog: flip-flop FIFO for the event data path, between the event builder and the
// TX/serializer logic.
//   clk, reset_n               clock and asynchronous active-low reset
//   data_in, write_n           write data and active-low write strobe
//   read_n                     active-low read/pop strobe
//   almost_full_thresh         fifo_almost_full  = count >= threshold
//   almost_empty_thresh        fifo_almost_empty = count <= threshold
//   clear_stats                zero overflow/underflow counts, reload high_water
//   data_out, data_valid       popped word (standard) or head word (FWFT)
//   fifo_counter, fifo_*       registered occupancy and flags
//   overflow_cnt/underflow_cnt saturating dropped-write / rejected-read counts
//   high_water                 peak occupancy since reset or clear_stats
module fifo_ff_prog #(
  parameter int unsigned FIFO_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned FIFO_BITS  = 8,
  parameter bit          FWFT       = 1'b0,
  parameter int unsigned STAT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [FIFO_BITS:0]    almost_full_thresh,
  input  logic [FIFO_BITS:0]    almost_empty_thresh,
  input  logic                  clear_stats,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [FIFO_BITS:0]    fifo_counter,
  output logic                  fifo_full,
  output logic                  fifo_half,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic [STAT_BITS-1:0]  overflow_cnt,
  output logic [STAT_BITS-1:0]  underflow_cnt,
  output logic [FIFO_BITS:0]    high_water
);

  localparam logic [FIFO_BITS:0]   DepthCnt = (FIFO_BITS+1)'(FIFO_DEPTH);
  localparam logic [FIFO_BITS:0]   HalfCnt  = (FIFO_BITS+1)'(FIFO_DEPTH / 2);
  localparam logic [FIFO_BITS:0]   CntOne   = (FIFO_BITS+1)'(1);
  localparam logic [FIFO_BITS-1:0] PtrOne   = FIFO_BITS'(1);
  localparam logic [STAT_BITS-1:0] StatOne  = STAT_BITS'(1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [FIFO_BITS-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [FIFO_BITS:0]    count_q, count_d;
  logic                  is_full, is_empty;
  logic                  pop, push, ovf, unf;
  logic                  last_word;
  logic [FIFO_WIDTH-1:0] head_d;

  always_comb begin
    // Decisions use the pre-edge count, so a write into an empty FIFO never feeds a read.
    is_full  = (count_q == DepthCnt);
    is_empty = (count_q == '0);
    pop      = !read_n && !is_empty;
    push     = !write_n && (!is_full || pop);
    ovf      = !write_n && is_full && !pop;
    unf      = !read_n && is_empty;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end

    rd_ptr_d = pop ? (rd_ptr_q + PtrOne) : rd_ptr_q;

    // Next FWFT head: when no stored word survives this edge the head is the word being
    // written now, which is not yet in mem.
    last_word = pop ? (count_q == CntOne) : is_empty;
    head_d    = last_word ? data_in : mem[rd_ptr_d];
  end

  // Storage has no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      data_out          <= '0;
      data_valid        <= 1'b0;
      fifo_full         <= 1'b0;
      fifo_half         <= 1'b0;
      fifo_empty        <= 1'b1;
      fifo_almost_full  <= 1'b0;
      fifo_almost_empty <= 1'b1;
      overflow_cnt      <= '0;
      underflow_cnt     <= '0;
      high_water        <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;

      fifo_full         <= (count_d == DepthCnt);
      fifo_half         <= (count_d >= HalfCnt);
      fifo_empty        <= (count_d == '0);
      fifo_almost_full  <= (count_d >= almost_full_thresh);
      fifo_almost_empty <= (count_d <= almost_empty_thresh);

      if (FWFT) begin
        if (count_d != '0) begin
          data_out <= head_d;
        end
        data_valid <= (count_d != '0);
      end else begin
        if (pop) begin
          data_out <= mem[rd_ptr_q];
        end
        data_valid <= pop;
      end

      if (clear_stats) begin
        overflow_cnt  <= '0;
        underflow_cnt <= '0;
        high_water    <= count_d;
      end else begin
        if (ovf && (overflow_cnt != '1)) begin
          overflow_cnt <= overflow_cnt + StatOne;
        end
        if (unf && (underflow_cnt != '1)) begin
          underflow_cnt <= underflow_cnt + StatOne;
        end
        if (count_d > high_water) begin
          high_water <= count_d;
        end
      end
    end
  end

  assign fifo_counter = count_q;

endmodule
